// File: rtl/sw_seq_pkg.sv
// Shared types and defaults for the multi-channel switch sequencer.
// Dwell limiting is compiled in with SW_SEQ_DWELL_EN.
package sw_seq_pkg;

  typedef enum logic {
    SW_TIMED = 1'b0,
    SW_RELAY = 1'b1
  } sw_mode_e;

  localparam int SW_NCH   = 4;
  localparam int SW_DEPTH = 8;
  localparam int SW_TW    = 16;
  localparam int SW_VW    = 12;
  localparam int SW_DWELL = 4;

  // Channel bookkeeping fields are sized for DEPTH and DWELL up to 255.
  localparam int SW_CNT_W = 8;

  typedef struct packed {
    logic                sw_on;
    logic [SW_CNT_W-1:0] ptr;
    logic [SW_CNT_W-1:0] len;
    logic [SW_CNT_W-1:0] dwell;
  } sw_chan_st_t;

  function automatic logic [SW_CNT_W-1:0] sw_clamp_len(input logic [SW_CNT_W-1:0] len,
                                                        input int depth);
    sw_clamp_len = (len > SW_CNT_W'(depth)) ? SW_CNT_W'(depth) : len;
  endfunction

endpackage

// File: rtl/sw_seq_chan.sv
// One switch channel: schedule table, pointer, relay comparator and dwell down-counter.
// Dwell blocking is active only when SW_SEQ_DWELL_EN is defined.
module sw_seq_chan
  import sw_seq_pkg::*;
#(
  parameter int DEPTH = SW_DEPTH,
  parameter int TW    = SW_TW,
  parameter int VW    = SW_VW,
  parameter int DWELL = SW_DWELL
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   mode,
  input  logic                   init,
  input  logic [TW-1:0]          now,
  input  logic                   tbl_we,
  input  logic [$clog2(DEPTH)-1:0] tbl_idx,
  input  logic [TW-1:0]          tbl_time,
  input  logic                   len_we,
  input  logic [$clog2(DEPTH):0] len_val,
  input  logic [VW-1:0]          vin,
  input  logic [VW-1:0]          vt,
  input  logic [VW-1:0]          vh,
  output logic                   sw_on,
  output logic                   sw_evt,
  output logic                   done
);

  localparam int AW = $clog2(DEPTH);

`ifdef SW_SEQ_DWELL_EN
  localparam logic DWELL_EN = 1'b1;
`else
  localparam logic DWELL_EN = 1'b0;
`endif

  // Loading DWELL-1 lets the next toggle land exactly DWELL edges after the last one.
  localparam logic [SW_CNT_W-1:0] DWELL_LOAD =
    (DWELL_EN && (DWELL > 1)) ? SW_CNT_W'(DWELL - 1) : '0;

  logic [TW-1:0] tbl_q [DEPTH];

  sw_chan_st_t st_q, st_d;
  logic        evt_q, evt_d;
  logic        done_q, done_d;
  sw_mode_e    mode_e;
  logic [VW:0] hi, lo;
  logic        timed_hit, relay_flip, allow;

  assign mode_e = sw_mode_e'(mode);

  always_ff @(posedge clk) begin
    if (tbl_we) tbl_q[tbl_idx] <= tbl_time;
  end

  always_comb begin
    hi = {1'b0, vt} + {1'b0, vh};
    lo = (vt > vh) ? {1'b0, vt - vh} : '0;

    timed_hit  = (mode_e == SW_TIMED) && (st_q.ptr < st_q.len) &&
                 (now >= tbl_q[st_q.ptr[AW-1:0]]);
    relay_flip = (mode_e == SW_RELAY) &&
                 (st_q.sw_on ? ({1'b0, vin} < lo) : ({1'b0, vin} > hi));
    allow      = (st_q.dwell == '0);

    st_d  = st_q;
    evt_d = 1'b0;

    if (st_q.dwell != '0) st_d.dwell = st_q.dwell - SW_CNT_W'(1);

    if ((timed_hit || relay_flip) && allow) begin
      st_d.sw_on = ~st_q.sw_on;
      st_d.dwell = DWELL_LOAD;
      evt_d      = 1'b1;
      if (timed_hit) st_d.ptr = st_q.ptr + SW_CNT_W'(1);
    end

    if (len_we) st_d.len = sw_clamp_len(SW_CNT_W'(len_val), DEPTH);

    // clr restarts the schedule but keeps lengths, so a same-cycle length write still lands.
    if (clr) begin
      st_d.sw_on = init;
      st_d.ptr   = '0;
      st_d.dwell = DWELL_LOAD;
      evt_d      = 1'b0;
    end

    done_d = !clr && (st_d.ptr >= st_d.len);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= '{sw_on: init, ptr: '0, len: '0, dwell: DWELL_LOAD};
      evt_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      evt_q  <= evt_d;
      done_q <= done_d;
    end
  end

  assign sw_on  = st_q.sw_on;
  assign sw_evt = evt_q;
  assign done   = done_q;

endmodule

// File: rtl/sw_seq.sv
// Multi-channel timed/hysteretic switch controller: time counter, cfg decode, channel array.
// Define SW_SEQ_DWELL_EN to enforce a minimum DWELL cycles between toggles per channel.
module sw_seq
  import sw_seq_pkg::*;
#(
  parameter int NCH   = SW_NCH,
  parameter int DEPTH = SW_DEPTH,
  parameter int TW    = SW_TW,
  parameter int VW    = SW_VW,
  parameter int DWELL = SW_DWELL
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic                     clr,
  input  logic                     cfg_we,
  input  logic [$clog2(NCH)-1:0]   cfg_ch,
  input  logic [$clog2(DEPTH)-1:0] cfg_idx,
  input  logic [TW-1:0]            cfg_time,
  input  logic                     cfg_len_we,
  input  logic [$clog2(DEPTH):0]   cfg_len,
  input  logic [NCH-1:0]           mode,
  input  logic [NCH-1:0]           init,
  input  logic [NCH*VW-1:0]        vin,
  input  logic [VW-1:0]            vt,
  input  logic [VW-1:0]            vh,
  output logic [NCH-1:0]           sw_on,
  output logic [NCH-1:0]           sw_evt,
  output logic [NCH-1:0]           done,
  output logic [TW-1:0]            now
);

  localparam int CW = $clog2(NCH);

  logic [TW-1:0]  now_q, now_d;
  logic [NCH-1:0] tbl_we, len_we;

  always_comb begin
    now_d = now_q;
    if (clr)                     now_d = '0;
    else if (run && (now_q != '1)) now_d = now_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) now_q <= '0;
    else        now_q <= now_d;
  end

  assign now = now_q;

  always_comb begin
    tbl_we = '0;
    len_we = '0;
    for (int c = 0; c < NCH; c++) begin
      tbl_we[c] = cfg_we     && (cfg_ch == CW'(c));
      len_we[c] = cfg_len_we && (cfg_ch == CW'(c));
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    sw_seq_chan #(
      .DEPTH(DEPTH),
      .TW   (TW),
      .VW   (VW),
      .DWELL(DWELL)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .mode    (mode[c]),
      .init    (init[c]),
      .now     (now_q),
      .tbl_we  (tbl_we[c]),
      .tbl_idx (cfg_idx),
      .tbl_time(cfg_time),
      .len_we  (len_we[c]),
      .len_val (cfg_len),
      .vin     (vin[c*VW +: VW]),
      .vt      (vt),
      .vh      (vh),
      .sw_on   (sw_on[c]),
      .sw_evt  (sw_evt[c]),
      .done    (done[c])
    );
  end

endmodule

// File: tb/tb_sw_seq.sv
// Directed bench for sw_seq with a 4-bit time base; expectations follow SW_SEQ_DWELL_EN.
module tb_sw_seq;

  localparam int NCH   = 4;
  localparam int DEPTH = 8;
  localparam int TW    = 4;
  localparam int VW    = 12;
  localparam int DWELL = 4;

`ifdef SW_SEQ_DWELL_EN
  localparam int DW_ON = 1;
`else
  localparam int DW_ON = 0;
`endif

  // Event "now" values as seen on the sampling edge after each toggle.
  localparam int T_DUP   = DW_ON ? 12 : 9;  // second entry of 7 in {3,7,7}
  localparam int R_FIRST = DW_ON ? 4  : 3;  // {2,3} replay, first toggle
  localparam int R_SECND = DW_ON ? 8  : 4;  // {2,3} replay, second toggle

  logic             clk = 1'b0;
  logic             rst_n, run, clr, cfg_we, cfg_len_we;
  logic [1:0]       cfg_ch;
  logic [2:0]       cfg_idx;
  logic [TW-1:0]    cfg_time;
  logic [3:0]       cfg_len;
  logic [NCH-1:0]   mode, init;
  logic [NCH*VW-1:0] vin;
  logic [VW-1:0]    vt, vh;
  logic [NCH-1:0]   sw_on, sw_evt, done;
  logic [TW-1:0]    now;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sw_seq #(.NCH(NCH), .DEPTH(DEPTH), .TW(TW), .VW(VW), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clr(clr),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_idx(cfg_idx), .cfg_time(cfg_time),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len),
    .mode(mode), .init(init), .vin(vin), .vt(vt), .vh(vh),
    .sw_on(sw_on), .sw_evt(sw_evt), .done(done), .now(now)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cfg_entry(input int ch, input int idx, input int t);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_idx = 3'(idx); cfg_time = TW'(t);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_length(input int ch, input int len);
    cfg_len_we = 1'b1; cfg_ch = 2'(ch); cfg_len = 4'(len);
    step();
    cfg_len_we = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init = 4'b0101; mode = '0; run = 1'b0;
    step(); step();
    checks++; if (sw_on !== 4'b0101) begin errors++; $display("FAIL reset_sw_on got %b want 0101", sw_on); end
    checks++; if (now !== 4'd0) begin errors++; $display("FAIL reset_now got %0d want 0", now); end
    checks++; if (sw_evt !== 4'b0000) begin errors++; $display("FAIL reset_evt got %b want 0000", sw_evt); end
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done got %b want 0000", done); end
    rst_n = 1'b1;
    step();
    checks++; if (done !== 4'b1111) begin errors++; $display("FAIL reset_done_next got %b want 1111", done); end
    checks++; if (sw_on !== 4'b0101) begin errors++; $display("FAIL reset_sw_hold got %b want 0101", sw_on); end
  endtask

  task automatic test_timed();
    int q[$];
    logic sw_at3, sw_at8, done_at5;
    int e0, e1, e2;
    init = 4'b0000; mode = '0;
    cfg_entry(0, 0, 3); cfg_entry(0, 1, 7); cfg_entry(0, 2, 7);
    cfg_length(0, 3);
    run = 1'b1;
    do_clr();
    sw_at3 = 1'bx; sw_at8 = 1'bx; done_at5 = 1'bx;
    for (int i = 0; i < 15; i++) begin
      if (now == 4'd3) sw_at3 = sw_on[0];
      if (now == 4'd5) done_at5 = done[0];
      if (now == 4'd8) sw_at8 = sw_on[0];
      if (sw_evt[0]) q.push_back(int'(now));
      step();
    end
    run = 1'b0;
    e0 = (q.size() > 0) ? q[0] : -1;
    e1 = (q.size() > 1) ? q[1] : -1;
    e2 = (q.size() > 2) ? q[2] : -1;
    checks++; if (q.size() != 3) begin errors++; $display("FAIL timed_evt_count got %0d want 3", q.size()); end
    checks++; if (e0 != 4) begin errors++; $display("FAIL timed_evt0_now got %0d want 4", e0); end
    checks++; if (e1 != 8) begin errors++; $display("FAIL timed_evt1_now got %0d want 8", e1); end
    checks++; if (e2 != T_DUP) begin errors++; $display("FAIL timed_evt2_now got %0d want %0d", e2, T_DUP); end
    checks++; if (sw_at3 !== 1'b0) begin errors++; $display("FAIL timed_sw_at3 got %b want 0", sw_at3); end
    checks++; if (sw_at8 !== 1'b0) begin errors++; $display("FAIL timed_sw_at8 got %b want 0", sw_at8); end
    checks++; if (done_at5 !== 1'b0) begin errors++; $display("FAIL timed_done_mid got %b want 0", done_at5); end
    checks++; if (sw_on[0] !== 1'b1) begin errors++; $display("FAIL timed_sw_end got %b want 1", sw_on[0]); end
    checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL timed_done_end got %b want 1", done[0]); end
  endtask

  task automatic test_relay();
    int vins [9] = '{105, 111, 105, 89, 90, 110, 111, 90, 89};
    logic exps [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int nevt = 0;
    vt = 12'd100; vh = 12'd10;
    vin = '0;
    mode = 4'b0010;
    for (int k = 0; k < 9; k++) begin
      vin[1*VW +: VW] = VW'(vins[k]);
      repeat (6) begin
        step();
        if (sw_evt[1]) nevt++;
      end
      checks++;
      if (sw_on[1] !== exps[k]) begin
        errors++; $display("FAIL relay_step%0d vin=%0d got %b want %b", k, vins[k], sw_on[1], exps[k]);
      end
    end
    checks++; if (nevt != 4) begin errors++; $display("FAIL relay_evt_count got %0d want 4", nevt); end
  endtask

  task automatic test_relay_underflow();
    int vins [3] = '{15, 16, 0};
    logic exps [3] = '{1'b0, 1'b1, 1'b1};
    vt = 12'd5; vh = 12'd10;
    vin = '0;
    mode = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      vin[2*VW +: VW] = VW'(vins[k]);
      repeat (8) step();
      checks++;
      if (sw_on[2] !== exps[k]) begin
        errors++; $display("FAIL underflow_step%0d vin=%0d got %b want %b", k, vins[k], sw_on[2], exps[k]);
      end
    end
  endtask

  task automatic test_len_clamp();
    int nevt = 0;
    mode = '0; run = 1'b0; vin = '0;
    for (int i = 0; i < DEPTH; i++) cfg_entry(2, i, 0);
    cfg_length(2, 12);
    do_clr();
    repeat (40) begin
      step();
      if (sw_evt[2]) nevt++;
    end
    checks++; if (nevt != 8) begin errors++; $display("FAIL clamp_evt_count got %0d want 8", nevt); end
    checks++; if (done[2] !== 1'b1) begin errors++; $display("FAIL clamp_done got %b want 1", done[2]); end
    checks++; if (sw_on[2] !== 1'b0) begin errors++; $display("FAIL clamp_sw got %b want 0", sw_on[2]); end
  endtask

  task automatic test_saturation();
    int nevt = 0;
    int evt_now = -1;
    mode = '0;
    cfg_entry(3, 0, 15);
    cfg_length(3, 1);
    run = 1'b1;
    do_clr();
    repeat (20) begin
      step();
      if (sw_evt[3]) begin nevt++; evt_now = int'(now); end
    end
    run = 1'b0;
    checks++; if (now !== 4'd15) begin errors++; $display("FAIL sat_now got %0d want 15", now); end
    checks++; if (nevt != 1) begin errors++; $display("FAIL sat_evt_count got %0d want 1", nevt); end
    checks++; if (evt_now != 15) begin errors++; $display("FAIL sat_evt_now got %0d want 15", evt_now); end
    checks++; if (sw_on[3] !== 1'b1) begin errors++; $display("FAIL sat_sw got %b want 1", sw_on[3]); end
    checks++; if (done[3] !== 1'b1) begin errors++; $display("FAIL sat_done got %b want 1", done[3]); end
  endtask

  task automatic test_clr_replay();
    int q[$];
    int found = 0;
    int first_now = -1;
    int e0, e1;
    init = 4'b0000; mode = '0; run = 1'b0;
    cfg_entry(0, 0, 2); cfg_entry(0, 1, 3);
    cfg_length(0, 2);
    run = 1'b1;
    do_clr();
    for (int i = 0; i < 20; i++) begin
      if (sw_evt[0]) begin found = 1; first_now = int'(now); break; end
      step();
    end
    checks++; if (found != 1) begin errors++; $display("FAIL replay_first_timeout got %0d want 1", found); end
    checks++; if (first_now != R_FIRST) begin errors++; $display("FAIL replay_first_now got %0d want %0d", first_now, R_FIRST); end
    do_clr();
    checks++; if (sw_on[0] !== 1'b0) begin errors++; $display("FAIL replay_clr_sw got %b want 0", sw_on[0]); end
    checks++; if (sw_evt[0] !== 1'b0) begin errors++; $display("FAIL replay_clr_evt got %b want 0", sw_evt[0]); end
    checks++; if (now !== 4'd0) begin errors++; $display("FAIL replay_clr_now got %0d want 0", now); end
    repeat (12) begin
      step();
      if (sw_evt[0]) q.push_back(int'(now));
    end
    run = 1'b0;
    e0 = (q.size() > 0) ? q[0] : -1;
    e1 = (q.size() > 1) ? q[1] : -1;
    checks++; if (q.size() != 2) begin errors++; $display("FAIL replay_evt_count got %0d want 2", q.size()); end
    checks++; if (e0 != R_FIRST) begin errors++; $display("FAIL replay_evt0_now got %0d want %0d", e0, R_FIRST); end
    checks++; if (e1 != R_SECND) begin errors++; $display("FAIL replay_evt1_now got %0d want %0d", e1, R_SECND); end
    checks++; if (sw_on[0] !== 1'b0) begin errors++; $display("FAIL replay_sw_end got %b want 0", sw_on[0]); end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; clr = 1'b0;
    cfg_we = 1'b0; cfg_len_we = 1'b0; cfg_ch = '0; cfg_idx = '0; cfg_time = '0; cfg_len = '0;
    mode = '0; init = '0; vin = '0; vt = '0; vh = '0;
    test_reset();
    test_timed();
    test_relay();
    test_relay_underflow();
    test_len_clamp();
    test_saturation();
    test_clr_replay();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_seq.md
# sw_seq

Multi-channel timed/hysteretic switch controller: the clocked successor to the single-channel `Switch` and `Relais` device maps. Each of NCH channels either follows a programmable toggle schedule or acts as a hysteretic relay on a digitised control sample. Its `sw_on` vector drives the resistive switch models (Ron/Roff selection) in mixed-mode netlists.

## Interface
- NCH, 4, number of switch channels
- DEPTH, 8, schedule entries per channel
- TW, 16, time-counter and schedule-entry width
- VW, 12, control-sample width (unsigned)
- DWELL, 4, minimum cycles between toggles (only with dwell macro)

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- run  in  1  time counter advances while high
- clr  in  1  sync clear of counter, pointers, `done`; schedule table kept
- cfg_we  in  1  write schedule entry
- cfg_ch  in  $clog2(NCH)  target channel for cfg writes
- cfg_idx  in  $clog2(DEPTH)  entry index
- cfg_time  in  TW  toggle time
- cfg_len_we  in  1  write schedule length for cfg_ch
- cfg_len  in  $clog2(DEPTH)+1  valid entries, 0..DEPTH
- mode  in  NCH  per channel: 0 timed, 1 relay
- init  in  NCH  switch state loaded on reset/clr
- vin  in  NCH*VW  relay control samples, channel c at [c*VW +: VW]
- vt  in  VW  relay threshold (shared)
- vh  in  VW  relay hysteresis (shared)
- sw_on  out  NCH  switch state
- sw_evt  out  NCH  one-cycle pulse when sw_on changes
- done  out  NCH  timed channel has consumed all entries
- now  out  TW  current time count

## Operation
- Reset (rst_n=0 at edge): now=0, all pointers=0, all lengths=0, done=0 (a channel with len 0 reports done=1 from the next cycle), sw_evt=0, sw_on=init. Table contents unspecified.
- Time counter: now increments when run=1; saturates at 2^TW-1, never wraps.
- Timed channel c: if ptr<len and now >= entry[ptr], toggle sw_on and ptr++. At most one toggle per channel per cycle; duplicate or past entries therefore toggle on consecutive cycles. done = (ptr >= len).
- Relay channel c: hi = vt+vh, lo = vt-vh, both computed in VW+1 bits; lo saturates to 0. sw_on→1 if vin>hi; sw_on→0 if vin<lo; otherwise hold. Pointer frozen in relay mode.
- Mode change takes effect at the next edge; sw_on is held across the change.
- clr: now=0, ptr=0, sw_on=init, sw_evt=0; lengths and table kept. rst_n has priority over clr.
- cfg writes are accepted any cycle, including during run; a newly written entry or length applies from the next edge. cfg_we with clr in the same cycle: both take effect.
- cfg_len > DEPTH is clamped to DEPTH.

## Timing
- All outputs registered.
- Condition true at edge k → sw_on and sw_evt change after edge k+1, i.e. one cycle latency from `now` reaching an entry.
- `now` shows the pre-increment value used for comparison in that cycle.
- sw_evt is high exactly one cycle per toggle and is never asserted on reset or clr.

## Configuration
- `SW_SEQ_DWELL_EN` defined: a per-channel dwell counter blocks any toggle within DWELL cycles of the previous one (reset/clr count as a toggle).
  - Timed mode: a blocked toggle is deferred and the pointer is held.
  - Relay mode: the condition is re-evaluated once the dwell expires.
- Macro undefined: no dwell logic; a toggle is allowed every cycle; DWELL is ignored.

## Structure
- Package `sw_seq_pkg`: mode encoding (`SW_TIMED`, `SW_RELAY`), default width localparams, channel-state struct (sw_on, ptr, len, dwell count).
- Sub-module `sw_seq_chan`: one channel (schedule RAM, pointer, relay comparator, dwell counter), instantiated NCH times under a generate loop. The top level holds the time counter and cfg decode.

## Test plan
- Reset with init=4'b0101 → sw_on=0101, now=0, sw_evt=0, done=1111 one cycle later.
- Ch0 timed, entries {3,7,7}, len=3, init=0, run=1 → sw_on[0]=1 after now=3, 0 after now=7, 1 one cycle later; done[0]=1; three sw_evt pulses.
- Ch1 relay, vt=100, vh=10: vin 105→111→105→89 → sw_on[1] 0,1,1,0.
- Relay underflow: vt=5, vh=10, vin=0 → lo=0, sw_on stays 1 once set.
- Saturation: TW=4, run held → now sticks at 15; an entry of 15 still toggles once.
- With SW_SEQ_DWELL_EN, DWELL=4, entries {2,3} → second toggle deferred to 4 cycles after the first; clr mid-schedule → sw_on=init, ptr=0, schedule replays.
